// File: rtl/serial_and_unit.sv
// Bit-serial bitwise AND: latches two WIDTH-bit operands, builds a & b one bit
// per clock (LSB first), then presents the word plus any/all reduction flags.
module serial_and_unit #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic             any_set,
  output logic             all_set,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] result_next;
  logic             accept;
  logic             last_bit;
  logic             consume;

  // start_ready is the only combinational output; reset masks it immediately.
  assign start_ready = (state == IDLE) && !reset;

  // NOTE: every sequential block uses non-blocking assignments so all flops
  // sample the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: defaults come first so every path assigns every signal and no
  // latch is inferred.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_bit   = 1'b0;
    consume    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_valid) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (count == LAST) begin
          last_bit   = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (result_ready) begin
          consume    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The word as it will look after this edge's bit lands; flags on the final
  // edge are taken from this so they reflect the completed result.
  always_comb begin
    result_next        = result;
    result_next[count] = a_sh[0] & b_sh[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count        <= '0;
      a_sh         <= '0;
      b_sh         <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      any_set      <= 1'b0;
      all_set      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      if (accept) begin
        a_sh   <= a_in;
        b_sh   <= b_in;
        result <= '0;
        count  <= '0;
        busy   <= 1'b1;
      end
      if (state == SHIFT) begin
        result <= result_next;
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        if (last_bit) begin
          result_valid <= 1'b1;
          any_set      <= |result_next;
          all_set      <= &result_next;
        end else begin
          count <= count + CW'(1);
        end
      end
      // result itself is left alone so it stays readable until the next accept.
      if (consume) begin
        result_valid <= 1'b0;
        any_set      <= 1'b0;
        all_set      <= 1'b0;
        busy         <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_and_unit.sv
// Directed and randomized checks of serial_and_unit against a word-level
// reference: result = a & b, latency WIDTH edges, handshake rules, reset abort.
module tb_serial_and_unit;

  localparam int WIDTH = 6;

  logic             clk = 1'b0;
  logic             reset;
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             result_valid;
  logic             result_ready;
  logic [WIDTH-1:0] result;
  logic             any_set;
  logic             all_set;
  logic             busy;

  serial_and_unit #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .a_in         (a_in),
    .b_in         (b_in),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result),
    .any_set      (any_set),
    .all_set      (all_set),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;
  int acc_q[$];

  always @(posedge clk) cyc++;

  // Inputs move only just after a rising edge, so the falling edge sees
  // exactly what the next rising edge will sample.
  always @(negedge clk) begin
    if (mon_en && start_valid && start_ready) acc_q.push_back(cyc);
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [WIDTH-1:0] r;
    logic             any;
    logic             all;
  } exp_t;

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    e.r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (a[i] && b[i]) e.r[i] = 1'b1;
    end
    e.any = (e.r != '0);
    e.all = (e.r == {WIDTH{1'b1}});
    return e;
  endfunction

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkw(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_done(input string tag, input exp_t e);
    check1({tag, "_valid"}, result_valid, 1'b1);
    checkw({tag, "_result"}, result, e.r);
    check1({tag, "_any"}, any_set, e.any);
    check1({tag, "_all"}, all_set, e.all);
    check1({tag, "_busy"}, busy, 1'b1);
    check1({tag, "_sready"}, start_ready, 1'b0);
  endtask

  // One full transaction: accept, WIDTH shift edges with junk on the inputs,
  // 'stall' cycles of backpressure, then a single consume edge.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int stall);
    exp_t e;
    e = model(a, b);
    check1("op_pre_ready", start_ready, 1'b1);
    start_valid  = 1'b1;
    a_in         = a;
    b_in         = b;
    result_ready = 1'b0;
    step();
    for (int k = 0; k < WIDTH; k++) begin
      check1("op_shift_valid", result_valid, 1'b0);
      check1("op_shift_busy", busy, 1'b1);
      check1("op_shift_sready", start_ready, 1'b0);
      start_valid  = 1'($urandom);
      a_in         = WIDTH'($urandom);
      b_in         = WIDTH'($urandom);
      result_ready = 1'($urandom);
      step();
    end
    check_done("op_done", e);
    for (int s = 0; s < stall; s++) begin
      start_valid  = 1'b1;
      a_in         = WIDTH'($urandom);
      b_in         = WIDTH'($urandom);
      result_ready = 1'b0;
      step();
      check_done("op_hold", e);
    end
    start_valid  = 1'b0;
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    check1("op_consumed_valid", result_valid, 1'b0);
    check1("op_consumed_any", any_set, 1'b0);
    check1("op_consumed_all", all_set, 1'b0);
    check1("op_consumed_busy", busy, 1'b0);
    check1("op_consumed_sready", start_ready, 1'b1);
    checkw("op_consumed_result", result, e.r);
  endtask

  initial begin
    exp_t e;
    logic [WIDTH-1:0] a, b;
    int n_b2b;

    reset        = 1'b1;
    start_valid  = 1'b0;
    result_ready = 1'b0;
    a_in         = '0;
    b_in         = '0;
    step();
    step();
    check1("rst_sready", start_ready, 1'b0);
    check1("rst_valid", result_valid, 1'b0);
    checkw("rst_result", result, '0);
    check1("rst_any", any_set, 1'b0);
    check1("rst_all", all_set, 1'b0);
    check1("rst_busy", busy, 1'b0);
    reset = 1'b0;
    #1;
    check1("rst_release_sready", start_ready, 1'b1);

    // Basic AND, then both flag extremes, then 5-cycle backpressure.
    run_op(6'b101101, 6'b111001, 0);
    run_op(6'h3F, 6'h3F, 0);
    run_op(6'h2A, 6'h15, 0);
    run_op(6'h37, 6'h1E, 5);

    // Reset aborts an operation in flight.
    start_valid = 1'b1;
    a_in        = 6'h3F;
    b_in        = 6'h3F;
    step();
    start_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
    check1("abort_sready_in_reset", start_ready, 1'b0);
    step();
    checkw("abort_result", result, '0);
    check1("abort_valid", result_valid, 1'b0);
    check1("abort_busy", busy, 1'b0);
    check1("abort_sready", start_ready, 1'b0);
    reset = 1'b0;
    #1;
    check1("abort_release_sready", start_ready, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      check1("abort_no_emit", result_valid, 1'b0);
    end
    run_op(6'h0F, 6'h3C, 0);
    checkw("abort_followup", result, 6'h0C);

    // Randomized transactions with random backpressure.
    for (int n = 0; n < 20; n++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), $urandom_range(0, 3));
    end

    // Back-to-back: start_valid and result_ready held high throughout.
    n_b2b = 6;
    acc_q.delete();
    mon_en       = 1'b1;
    start_valid  = 1'b1;
    result_ready = 1'b1;
    for (int n = 0; n < n_b2b; n++) begin
      a    = WIDTH'($urandom);
      b    = WIDTH'($urandom);
      e    = model(a, b);
      a_in = a;
      b_in = b;
      step();
      for (int k = 0; k < WIDTH; k++) begin
        check1("b2b_shift_valid", result_valid, 1'b0);
        check1("b2b_no_accept_busy", start_ready && busy, 1'b0);
        a_in = WIDTH'($urandom);
        b_in = WIDTH'($urandom);
        step();
      end
      check1("b2b_valid", result_valid, 1'b1);
      checkw("b2b_result", result, e.r);
      check1("b2b_any", any_set, e.any);
      check1("b2b_all", all_set, e.all);
      step();
      if (n == n_b2b - 1) start_valid = 1'b0;
      check1("b2b_consumed_valid", result_valid, 1'b0);
      check1("b2b_ready_after", start_ready, 1'b1);
    end
    result_ready = 1'b0;
    @(negedge clk);
    mon_en = 1'b0;
    checki("b2b_accept_count", acc_q.size(), n_b2b);
    for (int i = 1; i < acc_q.size(); i++) begin
      checki("b2b_interval", acc_q[i] - acc_q[i-1], WIDTH + 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_and_unit.md
# serial_and_unit

Multi-cycle, handshaked bitwise-AND unit for the processor datapath. It accepts two WIDTH-bit operands and computes their AND one bit per clock, LSB first. It returns the full WIDTH-bit result plus two reduction flags: any bit set, and all bits set. It serves multicycle/coprocessor paths that need the complete masked word rather than a single-bit gating decision, and it trades latency for a one-bit-wide datapath.

## Interface
- WIDTH, 6, operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock, sole clock domain.
- reset  input  1  synchronous, active-high; sampled on rising edge of clk.
- start_valid  input  1  operands on a_in/b_in are presented.
- start_ready  output  1  unit can accept operands; equals (state==IDLE) && !reset.
- a_in  input  WIDTH  operand A, sampled only on accept.
- b_in  input  WIDTH  operand B, sampled only on accept.
- result_valid  output  1  result, any_set and all_set are valid.
- result_ready  input  1  consumer accepts the result.
- result  output  WIDTH  a_in & b_in of the accepted operation.
- any_set  output  1  |result; 0 whenever result_valid=0.
- all_set  output  1  &result; 0 whenever result_valid=0.
- busy  output  1  high in SHIFT and DONE.

## Operation
- Reset behaviour:
  - All outputs are registered except start_ready.
  - On a reset edge: state=IDLE, bit counter=0, operand shift registers=0, result=0, result_valid=0, any_set=0, all_set=0, busy=0.
  - start_ready=0 while reset is high, and 1 in the first cycle after reset deasserts.
- State machine, three states:
  - IDLE: start_ready=1. An edge with start_valid=1 is an accept. On accept: latch a_in/b_in into shift registers, clear result to 0, clear counter to 0, go to SHIFT. With no start_valid, stay in IDLE.
  - SHIFT: each edge writes result[count] = a_sh[0] & b_sh[0], shifts both registers right by one, and increments count.
    - At the edge where count==WIDTH-1, the final bit is written instead, any_set/all_set are loaded from the completed word, result_valid is set to 1, and the state goes to DONE.
    - start_valid is ignored.
  - DONE: result, any_set and all_set are held stable. At an edge with result_ready=1: result_valid→0, any_set→0, all_set→0, state→IDLE.
    - result keeps its value until the next accept.
    - start_valid is ignored in DONE, so there is no same-edge re-accept.
- Width rules:
  - Counter width is clog2(WIDTH).
  - No arithmetic beyond the increment. The counter never exceeds WIDTH-1.
- Operand changes on a_in/b_in after accept have no effect on the operation in flight.

## Timing
- Accept at edge E0. Bits 0..WIDTH-1 are written at edges E0+1..E0+WIDTH.
- result_valid is high starting in the cycle after E0+WIDTH. Latency is WIDTH edges from accept to valid.
- If result_ready is already high, the result is consumed at E0+WIDTH+1 and start_ready=1 after it. The next accept is at E0+WIDTH+2, so the minimum initiation interval is WIDTH+2 cycles (8 for WIDTH=6).
- Backpressure is unbounded. Outputs are held bit-stable while result_valid=1 and result_ready=0.
- Reset has priority over every other event, including an accept or result handshake on the same edge. A reset in SHIFT or DONE aborts the operation and discards its result; nothing is emitted afterwards.
- result_ready while result_valid=0 has no effect.

## Test plan
- Basic AND (WIDTH=6): accept A=6'b101101, B=6'b111001 at E0; result_ready=1.
  - Required: result_valid rises exactly after E0+6.
  - Required: result=6'b101001, any_set=1, all_set=0.
  - Required: result_valid drops after E0+7.
- Flag extremes:
  - A=B=6'h3F → result=6'h3F, any_set=1, all_set=1.
  - A=6'h2A, B=6'h15 → result=6'h00, any_set=0, all_set=0.
- Backpressure: hold result_ready=0 for 5 cycles after valid, with start_valid=1 and changing a_in/b_in.
  - Required: result, flags and result_valid stay constant; start_ready=0; no second accept.
  - Release result_ready → consumed in one edge; start_ready=1 on the next cycle.
- Mid-operation reset: accept A=6'h3F, B=6'h3F, then assert reset for one edge at E0+3.
  - Required: result=0, result_valid=0, busy=0, start_ready=0 during reset and 1 after.
  - A subsequent accept with A=6'h0F, B=6'h3C yields 6'h0C after 6 edges.
- Back-to-back throughput: start_valid and result_ready tied high, with operands changing every accept.
  - Required: accepts spaced exactly 8 cycles apart.
  - Required: each result matches its own operands.
  - Required: start_valid is never accepted while busy=1.
